psa16_adder: RTL and testbench

- Registered 16-bit adder/subtractor with a packed-nibble mode.
- Word mode: one 16-bit two's-complement add or subtract, with a signed-overflow flag.
- Packed mode: four independent 4-bit signed saturating lanes (PADDSB-style).
- Serves the datapath both as the general ALU adder and as the PC incrementer/branch-target adder. Result and flag are registered once.

---
 rtl/psa16_adder.sv | 81 ++++++++
 tb/tb_psa16_adder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/psa16_adder.sv
// rtl/psa16_adder.sv - registered 16-bit adder/subtractor with packed 4x4-bit saturating mode
module psa16_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Sub,
  input  logic        pad,
  output logic [15:0] Sum,
  output logic        Ovfl
);

  logic [15:0] bb;
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] cv;
  logic [15:0] raw;
  logic [15:0] res;
  logic [3:0]  slice_cin;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [3:0]  lane_ov;
  logic        ovfl_next;

  always_comb begin
    bb        = Sub ? ~B : B;
    g         = A & bb;
    p         = A ^ bb;
    cv        = '0;
    raw       = '0;
    res       = '0;
    slice_cin = '0;
    grp_g     = '0;
    grp_p     = '0;
    lane_ov   = '0;
    ovfl_next = 1'b0;

    for (int i = 0; i < 4; i++) begin
      // Packed mode cuts the chain: every lane restarts with carry-in = Sub.
      if (i == 0 || pad)
        slice_cin[i] = Sub;
      else
        slice_cin[i] = grp_g[i-1] | (grp_p[i-1] & slice_cin[i-1]);

      cv[4*i]   = slice_cin[i];
      cv[4*i+1] = g[4*i] | (p[4*i] & slice_cin[i]);
      cv[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i])
                | (p[4*i+1] & p[4*i] & slice_cin[i]);
      cv[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                | (p[4*i+2] & p[4*i+1] & g[4*i])
                | (p[4*i+2] & p[4*i+1] & p[4*i] & slice_cin[i]);

      grp_g[i] = g[4*i+3] | (p[4*i+3] & g[4*i+2])
               | (p[4*i+3] & p[4*i+2] & g[4*i+1])
               | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      grp_p[i] = &p[4*i +: 4];

      raw[4*i +: 4] = p[4*i +: 4] ^ cv[4*i +: 4];
      lane_ov[i]    = (A[4*i+3] == bb[4*i+3]) && (raw[4*i+3] != A[4*i+3]);

      if (pad && lane_ov[i])
        res[4*i +: 4] = A[4*i+3] ? 4'h8 : 4'h7;
      else
        res[4*i +: 4] = raw[4*i +: 4];
    end

    // In word mode the top slice's sign check is the 16-bit overflow.
    ovfl_next = pad ? (|lane_ov) : lane_ov[3];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Sum  <= 16'h0000;
      Ovfl <= 1'b0;
    end else begin
      Sum  <= res;
      Ovfl <= ovfl_next;
    end
  end

endmodule

// File: tb/tb_psa16_adder.sv
// tb/tb_psa16_adder.sv - scoreboard bench for psa16_adder against an integer reference model
module tb_psa16_adder;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        Sub;
  logic        pad;
  logic [15:0] Sum;
  logic        Ovfl;

  int n_vec;
  int n_err;
  logic [16:0] exp_q[$];

  psa16_adder dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Sub  (Sub),
    .pad  (pad),
    .Sum  (Sum),
    .Ovfl (Ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic pk, input logic r);
    logic [15:0] s;
    logic        ov;
    int          sa, sb, res;
    logic signed [15:0] wa, wb;
    logic signed [3:0]  na, nb;
    s  = '0;
    ov = 1'b0;
    if (r) return 17'h0;
    if (!pk) begin
      wa  = a;
      wb  = b;
      sa  = wa;
      sb  = wb;
      res = sub ? sa - sb : sa + sb;
      s   = res[15:0];
      ov  = (res > 32767) || (res < -32768);
    end else begin
      for (int i = 0; i < 4; i++) begin
        na  = a[4*i +: 4];
        nb  = b[4*i +: 4];
        sa  = na;
        sb  = nb;
        res = sub ? sa - sb : sa + sb;
        if (res > 7) begin
          s[4*i +: 4] = 4'h7;
          ov = 1'b1;
        end else if (res < -8) begin
          s[4*i +: 4] = 4'h8;
          ov = 1'b1;
        end else begin
          s[4*i +: 4] = res[3:0];
        end
      end
    end
    return {ov, s};
  endfunction

  task automatic apply(input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic pk, input logic r);
    @(negedge clk);
    A   = a;
    B   = b;
    Sub = sub;
    pad = pk;
    rst = r;
    exp_q.push_back(model(a, b, sub, pk, r));
  endtask

  task automatic apply_chk(input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic pk, input logic [16:0] want);
    if (model(a, b, sub, pk, 1'b0) !== want)
      $display("note: reference model disagrees with directed value for %h %h", a, b);
    apply(a, b, sub, pk, 1'b0);
  endtask

  // Monitor: one result per edge, compared against the entry queued one cycle earlier.
  initial begin
    logic [16:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({Ovfl, Sum} !== e) begin
          n_err++;
          $display("FAIL result vec%0d: got Sum=%h Ovfl=%b, want Sum=%h Ovfl=%b",
                   n_vec, Sum, Ovfl, e[15:0], e[16]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra, rb;
    logic [15:0] corner [6];
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; A = '0; B = '0; Sub = 1'b0; pad = 1'b0;
    corner[0] = 16'h0000; corner[1] = 16'h7FFF; corner[2] = 16'h8000;
    corner[3] = 16'hFFFF; corner[4] = 16'h7777; corner[5] = 16'h8888;

    apply(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    apply_chk(16'h0000, 16'h0002, 1'b0, 1'b0, {1'b0, 16'h0002});
    apply_chk(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 16'h8000});
    apply_chk(16'hFFFE, 16'h0004, 1'b0, 1'b0, {1'b0, 16'h0002});
    apply_chk(16'h0005, 16'h0007, 1'b1, 1'b0, {1'b0, 16'hFFFE});
    apply_chk(16'h8000, 16'h0001, 1'b1, 1'b0, {1'b1, 16'h7FFF});
    apply_chk(16'h0000, 16'h8000, 1'b1, 1'b0, {1'b1, 16'h8000});
    apply_chk(16'h7171, 16'h1111, 1'b0, 1'b1, {1'b1, 16'h7272});
    apply_chk(16'h1234, 16'h1111, 1'b0, 1'b1, {1'b0, 16'h2345});
    apply_chk(16'h80F0, 16'h1010, 1'b1, 1'b1, {1'b1, 16'h80E0});

    // Back-to-back word ops with a single-edge reset in the middle.
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      apply(ra, rb, 1'($urandom), 1'b0, (i == 4));
    end

    for (int i = 0; i < 2000; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      apply(ra, rb, 1'($urandom), 1'($urandom), ($urandom_range(0, 63) == 0));
    end

    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
